audio_out_feeder: RTL and testbench
===================================

Name: audio_out_feeder

Overview:
- Downstream stage of the synth controller. Consumes the 32-bit two's-complement wave sample at a fixed audio sample rate and applies a power-of-two gain with saturation, plus mute.
- Buffers samples in a small FIFO and delivers them as mono-duplicated left/right words to the audio codec core using its allowed/write handshake.
- Reports FIFO occupancy and counts samples dropped on overflow.

Parameters:
- CLK_HZ, 50000000, system clock frequency.
- SAMPLE_HZ, 48000, audio sample rate. DIV = CLK_HZ/SAMPLE_HZ (integer division), must be >= 4.
- FIFO_DEPTH, 8, FIFO entries; power of two, >= 2.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- enable  input  1  1 = sample ticks run; 0 = tick counter held at 0, no new samples.
- mute  input  1  1 = scaled sample forced to 0 (still pushed).
- gain  input  3  left-shift amount 0..7 applied to the sample.
- wave_in  input  32  signed sample from the synth controller (wave_out).
- audio_out_allowed  input  1  codec FIFO can accept a write this cycle.
- write_audio_out  output  1  write strobe to the codec.
- left_channel_audio_out  output  32  sample to the codec, left channel.
- right_channel_audio_out  output  32  sample to the codec, right channel; always equal to left.
- sample_tick  output  1  one-cycle pulse at each sample instant.
- fifo_level  output  log2(FIFO_DEPTH)+1  current FIFO occupancy.
- drop_count  output  16  saturating count of samples dropped because the FIFO was full.

Behaviour:
- Reset (synchronous, reset=1 at the edge):
  - tick counter = 0, stage valid = 0, FIFO emptied (pointers and level 0), drop_count = 0.
  - All outputs 0 while reset is held, including left/right (FIFO output muxed to 0 when empty).
  - Reset mid-operation discards all buffered and in-flight samples, with no write strobe in the reset cycle.
- Tick counter:
  - Counts 0..DIV-1 while enable=1. sample_tick=1 in the cycle where counter==DIV-1, then the counter wraps to 0.
  - enable=0 holds the counter at 0 and sample_tick=0. Re-enabling gives the first tick DIV cycles later.
- Stage 1, capture/scale, registered at the edge ending a tick cycle:
  - s_data = sat32(wave_in <<< gain), or 0 if mute=1; s_valid = 1. Otherwise s_valid = 0.
  - sat32: compute in 40 bits signed. If > 0x7FFFFFFF, result = 0x7FFFFFFF; if < -2^31, result = 0x80000000; else the low 32 bits.
- Stage 2, push at the next edge when s_valid=1:
  - If the FIFO is not full, or a pop occurs in the same cycle, write s_data and advance the write pointer.
  - Otherwise drop the sample and increment drop_count, saturating at 0xFFFF.
- Pop / codec handshake:
  - write_audio_out = audio_out_allowed & ~empty (combinational). left/right = FIFO head (combinational).
  - When write_audio_out=1, the read pointer advances at that edge.
  - No bypass: a push into an empty FIFO is visible at the head the following cycle.
- Latency: tick cycle T → stage valid in T+1 → FIFO non-empty in T+2 → write_audio_out=1 in T+2 if allowed.
- Simultaneous push and pop: level unchanged. When full, the push is accepted because the pop frees the slot.
- Pointer wrap: pointers are modulo FIFO_DEPTH. The extra level bit distinguishes full (level==FIFO_DEPTH) from empty (level==0).
- Back-pressure: if audio_out_allowed stays low, the FIFO fills, then every further tick drops exactly one sample.
- enable=0 does not stop draining; buffered samples are still delivered.

Test Plan:
- Use CLK_HZ=8, SAMPLE_HZ=1 (DIV=8), FIFO_DEPTH=4.
- Basic path: release reset, enable=1, gain=0, wave_in=0x00001234, allowed=1.
  - sample_tick every 8 cycles; write_audio_out pulses 2 cycles after each tick; left=right=0x00001234; fifo_level returns to 0.
- Saturation:
  - wave_in=0x10000000, gain=3 → output 0x7FFFFFFF.
  - wave_in=0xF0000000, gain=3 → 0x80000000 (exact).
  - wave_in=0xF0000000, gain=4 → 0x80000000 (saturated).
  - wave_in=0xFFFFFFFF, gain=7 → 0xFFFFFF80.
- Mute: mute=1, wave_in=0x00005555 → writes still occur at the normal cadence with data 0x00000000.
- Overflow: allowed=0 for 6 ticks → fifo_level=4, drop_count=2. Then allowed=1 → 4 back-to-back writes of the first 4 samples in order, level 0.
- Full with concurrent pop: FIFO full, allowed rises in the same cycle a push is pending → push accepted, level stays 4, drop_count unchanged.
- Reset mid-stream: assert reset with 3 entries buffered → next cycle fifo_level=0, write_audio_out=0, drop_count=0. The first tick after deassertion comes 8 cycles later.

Source files
------------

// File: rtl/audio_out_feeder.sv
// audio_out_feeder: samples wave_in at the audio rate, applies gain/saturation/mute,
// buffers the result in a small FIFO and feeds it to the codec as mono left/right words.
module audio_out_feeder #(
  parameter int CLK_HZ     = 50000000,
  parameter int SAMPLE_HZ  = 48000,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          enable,
  input  logic                          mute,
  input  logic [2:0]                    gain,
  input  logic [31:0]                   wave_in,
  input  logic                          audio_out_allowed,
  output logic                          write_audio_out,
  output logic [31:0]                   left_channel_audio_out,
  output logic [31:0]                   right_channel_audio_out,
  output logic                          sample_tick,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [15:0]                   drop_count
);
  localparam int DIV = CLK_HZ / SAMPLE_HZ;
  localparam int CW  = $clog2(DIV);
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);
  localparam logic [AW:0]   FULL = (AW+1)'(FIFO_DEPTH);

  logic [CW-1:0] r_cnt;
  logic          r_sv;
  logic [31:0]   r_sd;
  logic [31:0]   r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wp, r_rp;
  logic [AW:0]   r_lvl;
  logic [15:0]   r_drop;

  logic signed [39:0] w_wide;
  logic [31:0]        w_sat;
  logic               w_tick, w_empty, w_full, w_pop, w_push, w_drop;

  // 40 bits hold any 32-bit value shifted by up to 7; overflow shows as bits 39:31 disagreeing
  assign w_wide  = $signed({{8{wave_in[31]}}, wave_in}) <<< gain;
  assign w_sat   = (&w_wide[39:31] || ~|w_wide[39:31]) ? w_wide[31:0]
                 : (w_wide[39] ? 32'h8000_0000 : 32'h7FFF_FFFF);
  assign w_tick  = enable & ~reset & (r_cnt == LAST);
  assign w_empty = r_lvl == '0;
  assign w_full  = r_lvl == FULL;
  assign w_pop   = audio_out_allowed & ~w_empty & ~reset;
  assign w_push  = r_sv & ~reset & (~w_full | w_pop);
  assign w_drop  = r_sv & ~reset & w_full & ~w_pop;

  assign sample_tick             = w_tick;
  assign write_audio_out         = w_pop;
  assign left_channel_audio_out  = (w_empty | reset) ? 32'h0 : r_mem[r_rp];
  assign right_channel_audio_out = left_channel_audio_out;
  assign fifo_level              = r_lvl;
  assign drop_count              = r_drop;

  always_ff @(posedge clk)
    if (w_push) r_mem[r_wp] <= r_sd;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt  <= '0;
      r_sv   <= 1'b0;
      r_sd   <= '0;
      r_wp   <= '0;
      r_rp   <= '0;
      r_lvl  <= '0;
      r_drop <= '0;
    end else begin
      r_cnt <= (!enable || r_cnt == LAST) ? '0 : r_cnt + 1'b1;
      r_sv  <= w_tick;
      r_sd  <= mute ? 32'h0 : w_sat;
      if (w_push) r_wp <= r_wp + 1'b1;
      if (w_pop) r_rp <= r_rp + 1'b1;
      r_lvl <= r_lvl + {{AW{1'b0}}, w_push} - {{AW{1'b0}}, w_pop};
      if (w_drop && r_drop != 16'hFFFF) r_drop <= r_drop + 16'd1;
    end
  end
endmodule

// File: tb/tb_audio_out_feeder.sv
// tb_audio_out_feeder: directed and random stimulus against a queue-based reference model.
module tb_audio_out_feeder;
  logic        clk = 1'b0;
  logic        reset, enable, mute, audio_out_allowed;
  logic [2:0]  gain;
  logic [31:0] wave_in;
  logic        write_audio_out, sample_tick;
  logic [31:0] left_channel_audio_out, right_channel_audio_out;
  logic [2:0]  fifo_level;
  logic [15:0] drop_count;

  audio_out_feeder #(.CLK_HZ(8), .SAMPLE_HZ(1), .FIFO_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .enable(enable), .mute(mute), .gain(gain),
    .wave_in(wave_in), .audio_out_allowed(audio_out_allowed),
    .write_audio_out(write_audio_out),
    .left_channel_audio_out(left_channel_audio_out),
    .right_channel_audio_out(right_channel_audio_out),
    .sample_tick(sample_tick), .fifo_level(fifo_level), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h expected=%h", tag, got, exp);
  endtask

  // reference model: enabled-cycle count, stage sample, FIFO contents, drop total
  int          n;
  bit          pv;
  logic [31:0] pd;
  logic [31:0] q[$];
  int          drops;
  logic [31:0] last_wr;

  function automatic logic [31:0] sat_ref(input logic [31:0] w, input logic [2:0] g);
    longint v;
    v = longint'($signed(w)) * (longint'(1) << g);
    if (v > 64'sh7FFF_FFFF) return 32'h7FFF_FFFF;
    if (v < -64'sh8000_0000) return 32'h8000_0000;
    return v[31:0];
  endfunction

  task automatic model_clear();
    n = 0; pv = 0; pd = 0; q.delete(); drops = 0;
  endtask

  task automatic step();
    bit          etick, ewr, full_before;
    logic [31:0] ehead;
    @(negedge clk);
    etick = !reset && enable && (n % 8 == 7);
    ewr   = !reset && audio_out_allowed && q.size() > 0;
    ehead = (reset || q.size() == 0) ? 32'h0 : q[0];
    chk("tick", 32'(sample_tick), 32'(etick));
    chk("write", 32'(write_audio_out), 32'(ewr));
    chk("left", left_channel_audio_out, ehead);
    chk("right", right_channel_audio_out, ehead);
    chk("level", 32'(fifo_level), 32'(q.size()));
    chk("drop", 32'(drop_count), 32'(drops));
    if (write_audio_out) last_wr = left_channel_audio_out;
    @(posedge clk);
    if (reset) model_clear();
    else begin
      full_before = q.size() >= 4;
      if (ewr) void'(q.pop_front());
      if (pv) begin
        if (!full_before || ewr) q.push_back(pd);
        else if (drops < 65535) drops++;
      end
      pv = etick;
      pd = mute ? 32'h0 : sat_ref(wave_in, gain);
      n  = enable ? n + 1 : 0;
    end
    #1;
  endtask

  task automatic run(input int cycles);
    for (int i = 0; i < cycles; i++) step();
  endtask

  task automatic phase(input string tag, input logic [31:0] w, input logic [2:0] g,
                       input logic m, input logic [31:0] exp);
    wave_in = w; gain = g; mute = m;
    run(20);
    chk(tag, last_wr, exp);
  endtask

  initial begin
    int          k;
    logic [15:0] d0;
    reset = 1; enable = 0; mute = 0; gain = 0; wave_in = 0; audio_out_allowed = 0;
    last_wr = 0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    run(2);
    reset = 0; enable = 1; wave_in = 32'h0000_1234; audio_out_allowed = 1;
    run(40);
    chk("basic_data", last_wr, 32'h0000_1234);
    phase("sat_pos", 32'h1000_0000, 3'd3, 1'b0, 32'h7FFF_FFFF);
    phase("neg_exact", 32'hF000_0000, 3'd3, 1'b0, 32'h8000_0000);
    phase("sat_neg", 32'hF000_0000, 3'd4, 1'b0, 32'h8000_0000);
    phase("neg_one_g7", 32'hFFFF_FFFF, 3'd7, 1'b0, 32'hFFFF_FF80);
    phase("mute", 32'h0000_5555, 3'd0, 1'b1, 32'h0);
    mute = 0;
    // overflow from a fresh reset so tick positions are known
    reset = 1;
    run(1);
    reset = 0; enable = 1; audio_out_allowed = 0; gain = 0;
    for (int i = 0; i < 50; i++) begin
      wave_in = $urandom;
      step();
    end
    chk("ovf_level", 32'(fifo_level), 32'd4);
    chk("ovf_drop", 32'(drop_count), 32'd2);
    k = 0;
    while (!pv && k < 16) begin
      step();
      k++;
    end
    chk("pend_found", 32'(pv), 32'd1);
    d0 = drop_count;
    audio_out_allowed = 1;
    step();
    chk("fullpop_level", 32'(fifo_level), 32'd4);
    chk("fullpop_drop", 32'(drop_count), 32'(d0));
    run(20);
    audio_out_allowed = 0;
    k = 0;
    while (q.size() != 3 && k < 40) begin
      step();
      k++;
    end
    chk("three_buffered", 32'(q.size()), 32'd3);
    reset = 1;
    run(1);
    chk("rst_level", 32'(fifo_level), 32'd0);
    chk("rst_drop", 32'(drop_count), 32'd0);
    reset = 0; audio_out_allowed = 1;
    run(20);
    for (int i = 0; i < 800; i++) begin
      reset = ($urandom_range(0, 199) == 0);
      enable = ($urandom_range(0, 9) != 0);
      mute = ($urandom_range(0, 7) == 0);
      gain = 3'($urandom_range(0, 7));
      wave_in = $urandom;
      audio_out_allowed = ($urandom_range(0, 2) != 0);
      step();
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
